// File: rtl/fifo_bank_seq.sv
// fifo_bank_seq: single-clock sequencer for the CNN input FIFO bank.
//   LOAD  - spreads an upstream word stream round-robin over ARRAY_SIZE FIFOs
//           through one shared write bus. A full FIFO stalls the whole stream.
//   DRAIN - issues FIFO read enables for cfg_len words per lane.
// Optional feature macro: FIFO_BANK_SEQ_SKEW_EN
//   defined   : diagonal skew, lane i starts i cycles after lane 0
//   undefined : all lanes read in lockstep
module fifo_bank_seq #(
    parameter int ARRAY_SIZE = 9,
    parameter int DATA_SIZE  = 8,
    parameter int LEN_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_load,
    input  logic                  cmd_drain,
    input  logic [LEN_W-1:0]      cfg_len,
    input  logic                  in_valid,
    input  logic [DATA_SIZE-1:0]  in_data,
    output logic                  in_ready,
    input  logic [ARRAY_SIZE-1:0] fifo_full,
    input  logic [ARRAY_SIZE-1:0] fifo_empty,
    input  logic                  out_stall,
    output logic [DATA_SIZE-1:0]  w_bus,
    output logic [ARRAY_SIZE-1:0] w_en,
    output logic [ARRAY_SIZE-1:0] r_en,
    output logic [ARRAY_SIZE-1:0] out_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int COL_W = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
    // Wide enough for cfg_len + ARRAY_SIZE with the largest cfg_len.
    localparam int CNT_W = LEN_W + $clog2(ARRAY_SIZE) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state;
    logic [COL_W-1:0]      col;
    logic [CNT_W-1:0]      row;
    logic [CNT_W-1:0]      t;
    logic [CNT_W-1:0]      len;
    logic [CNT_W-1:0]      t_last;
    logic [ARRAY_SIZE-1:0] due;
    logic                  accept;
    logic                  last_col;
    logic                  last_word;

    assign busy      = (state != IDLE);
    assign in_ready  = (state == LOAD) && !fifo_full[col];
    assign accept    = in_valid && in_ready;
    assign last_col  = (col == COL_W'(ARRAY_SIZE - 1));
    assign last_word = last_col && (row == len - CNT_W'(1));

`ifdef FIFO_BANK_SEQ_SKEW_EN
    assign t_last = len + CNT_W'(ARRAY_SIZE) - CNT_W'(2);
`else
    assign t_last = len - CNT_W'(1);
`endif

    // Lanes whose read window covers the current drain step.
    always_comb begin
        // NOTE: default assignment first so no path leaves due unassigned (no latch).
        due = '0;
        for (int i = 0; i < ARRAY_SIZE; i++) begin
`ifdef FIFO_BANK_SEQ_SKEW_EN
            due[i] = (t >= CNT_W'(i)) && (t < CNT_W'(i) + len);
`else
            due[i] = (t < len);
`endif
        end
    end

    // Sequencer FSM with registered enables, bus and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            col       <= '0;
            row       <= '0;
            t         <= '0;
            len       <= '0;
            w_bus     <= '0;
            w_en      <= '0;
            r_en      <= '0;
            out_valid <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            w_en      <= '0;
            r_en      <= '0;
            done      <= 1'b0;
            out_valid <= r_en;
            case (state)
                IDLE: begin
                    if (cmd_load || cmd_drain) begin
                        len <= CNT_W'(cfg_len);
                        col <= '0;
                        row <= '0;
                        t   <= '0;
                        if (cfg_len == '0) begin
                            done <= 1'b1;
                        end else if (cmd_load) begin
                            state <= LOAD;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        w_en  <= ARRAY_SIZE'(1) << col;
                        w_bus <= in_data;
                        if (last_col) begin
                            col <= '0;
                            row <= row + CNT_W'(1);
                        end else begin
                            col <= col + COL_W'(1);
                        end
                        if (last_word) begin
                            state <= DONE;
                        end
                    end
                end
                DRAIN: begin
                    if (!out_stall) begin
                        r_en <= due & ~fifo_empty;
                        if (|(due & fifo_empty)) begin
                            err <= 1'b1;
                        end
                        if (t == t_last) begin
                            state <= DONE;
                        end else begin
                            t <= t + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fifo_bank_seq.md
Name: fifo_bank_seq

Overview:
- Single-clock sequencer for the CNN input FIFO bank: ARRAY_SIZE FIFOs sharing one write data bus, each with its own w_en/r_en and full/empty.
- LOAD: distributes an upstream word stream round-robin across the FIFOs, one word per FIFO per row.
- DRAIN: issues diagonally skewed reads so lane i starts i cycles after lane 0, producing the wavefront the systolic PE array expects.

Parameters:
- ARRAY_SIZE, 9, number of FIFOs/lanes.
- DATA_SIZE, 8, data word width.
- LEN_W, 8, width of cfg_len (words per FIFO per command).

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cmd_load  input  1  start-load pulse, sampled in IDLE.
- cmd_drain  input  1  start-drain pulse, sampled in IDLE.
- cfg_len  input  LEN_W  words per FIFO, latched on command acceptance.
- in_valid  input  1  upstream word valid.
- in_data  input  DATA_SIZE  upstream word.
- in_ready  output  1  upstream ready.
- fifo_full  input  ARRAY_SIZE  per-FIFO full.
- fifo_empty  input  ARRAY_SIZE  per-FIFO empty.
- out_stall  input  1  downstream hold during DRAIN.
- w_bus  output  DATA_SIZE  shared FIFO write data (registered).
- w_en  output  ARRAY_SIZE  one-hot FIFO write enables (registered).
- r_en  output  ARRAY_SIZE  FIFO read enables (registered).
- out_valid  output  ARRAY_SIZE  r_en delayed 1 cycle; marks FIFO dataOut valid.
- busy  output  1  high when not IDLE.
- done  output  1  one-cycle completion pulse.
- err  output  1  sticky underflow flag.

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0; err cleared. Reset mid-operation aborts immediately with no further enables.
- States and transitions:
  - IDLE: cmd_load -> LOAD; cmd_drain -> DRAIN; both high -> LOAD wins and cmd_drain is dropped. Commands outside IDLE are ignored. cfg_len=0 -> no enables, done pulses next cycle, stay IDLE.
  - LOAD: col pointer 0..ARRAY_SIZE-1 and row counter 0..cfg_len-1.
    - in_ready = (state==LOAD) & ~fifo_full[col].
    - Handshake accepted when in_valid & in_ready. Next cycle: w_en = one-hot(col), w_bus = in_data.
    - col increments; wrap to 0 increments row.
    - After word ARRAY_SIZE*cfg_len is accepted -> DONE.
    - A full FIFO stalls the whole stream; no word is skipped.
  - DRAIN: cycle counter t = 0..cfg_len+ARRAY_SIZE-2.
    - Next-cycle r_en[i] = (t>=i) & (t<i+cfg_len) & ~out_stall & ~fifo_empty[i].
    - out_stall high -> t holds and r_en = 0.
    - Lane due but fifo_empty[i] -> read suppressed, err set (sticky until reset).
    - After the last t is issued -> DONE.
  - DONE: done=1 for one cycle (aligned with the final w_en/r_en cycle + 1) -> IDLE.
- Latency: accepted word -> w_en 1 cycle; r_en -> out_valid 1 cycle.
- Counters are LEN_W+$clog2(ARRAY_SIZE)+1 bits wide and never overflow for max cfg_len.

Optional Feature:
- Macro FIFO_BANK_SEQ_SKEW_EN.
- Defined: diagonal skew as above; drain lasts cfg_len+ARRAY_SIZE-1 non-stalled cycles.
- Undefined: all lanes read in lockstep, r_en[i] = (t<cfg_len) & ~out_stall & ~fifo_empty[i]; drain lasts cfg_len non-stalled cycles. Load path is unchanged.

Test Plan:
- ARRAY_SIZE=3, cfg_len=2, continuous in_valid with words 1..6 -> w_en sequence 001,010,100,001,010,100 carrying w_bus 1..6; done 1 cycle after last w_en; busy low after.
- Skew on, cfg_len=2, all FIFOs non-empty, cmd_drain -> r_en over 4 cycles: 001,011,110,100; out_valid same pattern 1 cycle later; done pulse follows.
- fifo_full[1]=1 for 3 cycles while col=1 -> in_ready low for those 3 cycles, no w_en; load resumes at lane 1 with the pending word.
- out_stall high 2 cycles mid-drain -> r_en=000 for 2 cycles; remaining pattern continues unchanged.
- fifo_empty[2]=1 when lane 2 due -> r_en[2] stays 0, err=1 and stays 1 until rst_n low.
- cmd_load & cmd_drain together in IDLE -> LOAD entered; rst_n asserted mid-load -> all outputs 0 asynchronously, state IDLE.
